// File: rtl/gbox_rx_word_align.sv
// gbox_rx_word_align: searches the gearbox RX word stream for a training
// pattern and issues bitslip requests until the word boundary locks. Once
// locked, it watches for runs of mismatches and reports loss of alignment.
module gbox_rx_word_align #(
  parameter int PAR_DWID      = 10,
  parameter int PAR_MATCH_CNT = 4,
  parameter int PAR_LOSS_CNT  = 8,
  parameter int PAR_SLIP_WAIT = 3
) (
  input  logic                core_clk,
  input  logic                rx_reset,
  input  logic                align_start,
  input  logic [PAR_DWID-1:0] cfg_pattern,
  input  logic                cfg_auto_relock,
  input  logic [PAR_DWID-1:0] rx_data,
  input  logic                rx_dvalid,
  output logic                bitslip_adj,
  output logic                align_busy,
  output logic                align_done,
  output logic                align_error,
  output logic                align_lost,
  output logic [3:0]          slip_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_ERROR
  } state_t;

  localparam logic [3:0] SLIP_MAX  = 4'(PAR_DWID);
  localparam logic [3:0] MATCH_LIM = 4'(PAR_MATCH_CNT);
  localparam logic [7:0] LOSS_LIM  = 8'(PAR_LOSS_CNT);
  localparam logic [3:0] WAIT_LIM  = 4'(PAR_SLIP_WAIT);

  state_t     state_q, state_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic       bitslip_q, bitslip_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic       lost_q, lost_d;

  logic       word_match;
  logic       match_last;
  logic       loss_last;
  logic       wait_last;

  assign word_match = (rx_data == cfg_pattern);
  assign match_last = ((match_cnt_q + 4'd1) == MATCH_LIM);
  assign loss_last  = ((loss_cnt_q + 8'd1) == LOSS_LIM);
  assign wait_last  = ((wait_cnt_q + 4'd1) == WAIT_LIM);

  // State and output register; reset clears everything without a clock.
  always_ff @(posedge core_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= 4'd0;
      loss_cnt_q  <= 8'd0;
      wait_cnt_q  <= 4'd0;
      slip_cnt_q  <= 4'd0;
      bitslip_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      bitslip_q   <= bitslip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      lost_q      <= lost_d;
    end
  end

  // Next-state logic; a start request overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (align_start) begin
      state_d = ST_SEARCH;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_SEARCH: begin
          if (rx_dvalid) begin
            if (!word_match)     state_d = ST_SLIP;
            else if (match_last) state_d = ST_LOCKED;
          end
        end
        ST_SLIP:   state_d = (slip_cnt_q == SLIP_MAX) ? ST_ERROR : ST_SETTLE;
        ST_SETTLE: begin
          if (rx_dvalid && wait_last) state_d = ST_SEARCH;
        end
        ST_LOCKED: begin
          if (rx_dvalid && !word_match && loss_last)
            state_d = cfg_auto_relock ? ST_SEARCH : ST_IDLE;
        end
        ST_ERROR:  state_d = ST_ERROR;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, bitslip pulse and status flags for the next cycle.
  always_comb begin
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    bitslip_d   = 1'b0;
    error_d     = error_q;
    lost_d      = lost_q;
    if (align_start) begin
      match_cnt_d = 4'd0;
      loss_cnt_d  = 8'd0;
      wait_cnt_d  = 4'd0;
      slip_cnt_d  = 4'd0;
      error_d     = 1'b0;
      lost_d      = 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (rx_dvalid) begin
            if (word_match && !match_last) match_cnt_d = match_cnt_q + 4'd1;
            else                           match_cnt_d = 4'd0;
          end
        end
        ST_SLIP: begin
          if (slip_cnt_q == SLIP_MAX) begin
            error_d = 1'b1;
          end else begin
            slip_cnt_d = slip_cnt_q + 4'd1;
            bitslip_d  = 1'b1;
          end
          wait_cnt_d = 4'd0;
        end
        ST_SETTLE: begin
          if (rx_dvalid) begin
            if (wait_last) begin
              wait_cnt_d  = 4'd0;
              match_cnt_d = 4'd0;
            end else begin
              wait_cnt_d = wait_cnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (rx_dvalid) begin
            if (word_match) begin
              loss_cnt_d = 8'd0;
            end else if (loss_last) begin
              loss_cnt_d  = 8'd0;
              match_cnt_d = 4'd0;
              lost_d      = 1'b1;
              if (cfg_auto_relock) slip_cnt_d = 4'd0;
            end else begin
              loss_cnt_d = loss_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Busy and done follow the state being entered so they register with it.
  always_comb begin
    busy_d = (state_d == ST_SEARCH) || (state_d == ST_SLIP) || (state_d == ST_SETTLE);
    done_d = (state_d == ST_LOCKED);
  end

  assign bitslip_adj = bitslip_q;
  assign align_busy  = busy_q;
  assign align_done  = done_q;
  assign align_error = error_q;
  assign align_lost  = lost_q;
  assign slip_count  = slip_cnt_q;

endmodule

// File: tb/tb_gbox_rx_word_align.sv
// Directed bench for gbox_rx_word_align: lock, slip search, error, loss,
// valid gaps, reset mid-pulse and restart while locked.
module tb_gbox_rx_word_align;

  localparam logic [9:0] PATTERN = 10'h3F0;

  logic       core_clk;
  logic       rx_reset;
  logic       align_start;
  logic [9:0] cfg_pattern;
  logic       cfg_auto_relock;
  logic [9:0] rx_data;
  logic       rx_dvalid;
  logic       bitslip_adj;
  logic       align_busy;
  logic       align_done;
  logic       align_error;
  logic       align_lost;
  logic [3:0] slip_count;

  int testsRun;
  int testsFailed;
  int pulses;
  int minGap;
  int cyc;
  bit timedOut;
  int extraPulses;

  gbox_rx_word_align #(
    .PAR_DWID(10),
    .PAR_MATCH_CNT(4),
    .PAR_LOSS_CNT(8),
    .PAR_SLIP_WAIT(3)
  ) dut (
    .core_clk(core_clk),
    .rx_reset(rx_reset),
    .align_start(align_start),
    .cfg_pattern(cfg_pattern),
    .cfg_auto_relock(cfg_auto_relock),
    .rx_data(rx_data),
    .rx_dvalid(rx_dvalid),
    .bitslip_adj(bitslip_adj),
    .align_busy(align_busy),
    .align_done(align_done),
    .align_error(align_error),
    .align_lost(align_lost),
    .slip_count(slip_count)
  );

  // Free-running core clock, 10 time units per period.
  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  // Rotate a word left, standing in for a misaligned gearbox boundary.
  function automatic logic [9:0] rotWord(input logic [9:0] w, input int n);
    int k;
    k = n % 10;
    return (w << k) | (w >> (10 - k));
  endfunction

  // Drive one cycle of inputs at a falling edge, return at the next falling
  // edge so the outputs show the effect of the sampled inputs.
  task automatic applyStimulus(input logic v, input logic [9:0] d, input logic start);
    rx_dvalid   = v;
    rx_data     = d;
    align_start = start;
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Feed the link model until lock or error; each observed bitslip moves the
  // rotation one step toward the true boundary.
  task automatic runLink(input int rot0, input bit useConst, input logic [9:0] constWord,
                         input bit gaps, input int budget);
    int rot;
    int lastPulse;
    logic v;
    logic [9:0] d;
    rot = rot0;
    lastPulse = -1;
    pulses = 0;
    minGap = 1000;
    cyc = 0;
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      v = gaps ? ((i % 2) == 0) : 1'b1;
      d = useConst ? constWord : rotWord(PATTERN, rot);
      applyStimulus(v, d, 1'b0);
      cyc = i + 1;
      if (bitslip_adj) begin
        pulses++;
        if (lastPulse >= 0 && (cyc - lastPulse) < minGap) minGap = cyc - lastPulse;
        lastPulse = cyc;
        rot = (rot + 9) % 10;
      end
      if (align_done || align_error) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    testsRun        = 0;
    testsFailed     = 0;
    rx_reset        = 1'b1;
    align_start     = 1'b0;
    cfg_pattern     = PATTERN;
    cfg_auto_relock = 1'b1;
    rx_data         = 10'h000;
    rx_dvalid       = 1'b0;
    @(negedge core_clk);
    @(negedge core_clk);
    checkOutput("reset_bitslip", 32'(bitslip_adj), 0);
    checkOutput("reset_busy", 32'(align_busy), 0);
    checkOutput("reset_done", 32'(align_done), 0);
    checkOutput("reset_error", 32'(align_error), 0);
    checkOutput("reset_lost", 32'(align_lost), 0);
    checkOutput("reset_slip_count", 32'(slip_count), 0);
    rx_reset = 1'b0;

    // Matching data without a start request keeps the block idle.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, PATTERN, 1'b0);
    checkOutput("idle_no_lock", 32'(align_done), 0);
    checkOutput("idle_not_busy", 32'(align_busy), 0);

    // Already aligned: lock after exactly four valid matches.
    applyStimulus(1'b0, 10'h000, 1'b1);
    checkOutput("start_busy", 32'(align_busy), 1);
    extraPulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, PATTERN, 1'b0);
      if (bitslip_adj) extraPulses++;
    end
    checkOutput("aligned_not_yet_done", 32'(align_done), 0);
    applyStimulus(1'b1, PATTERN, 1'b0);
    if (bitslip_adj) extraPulses++;
    checkOutput("aligned_done", 32'(align_done), 1);
    checkOutput("aligned_busy_low", 32'(align_busy), 0);
    checkOutput("aligned_slip_count", 32'(slip_count), 0);
    checkOutput("aligned_no_pulse", 32'(extraPulses), 0);

    // Loss: seven misses then a match resets the run; eight misses lose lock.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 10'h000, 1'b0);
    applyStimulus(1'b1, PATTERN, 1'b0);
    checkOutput("loss7_still_done", 32'(align_done), 1);
    checkOutput("loss7_not_lost", 32'(align_lost), 0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 10'h000, 1'b0);
    checkOutput("loss_run7_done", 32'(align_done), 1);
    applyStimulus(1'b1, 10'h000, 1'b0);
    checkOutput("loss8_lost", 32'(align_lost), 1);
    checkOutput("loss8_done_low", 32'(align_done), 0);
    checkOutput("loss8_relock_busy", 32'(align_busy), 1);

    // Loss without auto-relock falls back to idle; start clears the flag.
    applyStimulus(1'b0, 10'h000, 1'b1);
    checkOutput("restart_clears_lost", 32'(align_lost), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, PATTERN, 1'b0);
    checkOutput("relock_done", 32'(align_done), 1);
    cfg_auto_relock = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 10'h000, 1'b0);
    checkOutput("noauto_lost", 32'(align_lost), 1);
    checkOutput("noauto_idle_busy", 32'(align_busy), 0);
    checkOutput("noauto_done_low", 32'(align_done), 0);
    cfg_auto_relock = 1'b1;

    // Rotated by three bits, no gaps.
    applyStimulus(1'b0, 10'h000, 1'b1);
    runLink(3, 1'b0, 10'h000, 1'b0, 200);
    checkOutput("rot3_no_timeout", 32'(timedOut), 0);
    checkOutput("rot3_pulses", 32'(pulses), 3);
    checkOutput("rot3_min_gap", 32'(minGap), 5);
    checkOutput("rot3_latency", 32'(cyc), 19);
    checkOutput("rot3_slip_count", 32'(slip_count), 3);
    checkOutput("rot3_done", 32'(align_done), 1);

    // Restart while locked: flags and slip count clear, matching restarts.
    applyStimulus(1'b1, PATTERN, 1'b1);
    checkOutput("relstart_done_low", 32'(align_done), 0);
    checkOutput("relstart_busy", 32'(align_busy), 1);
    checkOutput("relstart_slip_clear", 32'(slip_count), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, PATTERN, 1'b0);
    checkOutput("relstart_3_not_done", 32'(align_done), 0);
    applyStimulus(1'b1, PATTERN, 1'b0);
    checkOutput("relstart_4_done", 32'(align_done), 1);

    // Same rotation with rx_dvalid toggling: same result, longer latency.
    applyStimulus(1'b0, 10'h000, 1'b1);
    runLink(3, 1'b0, 10'h000, 1'b1, 200);
    checkOutput("gap_no_timeout", 32'(timedOut), 0);
    checkOutput("gap_pulses", 32'(pulses), 3);
    checkOutput("gap_latency", 32'(cyc), 31);
    checkOutput("gap_slip_count", 32'(slip_count), 3);
    checkOutput("gap_done", 32'(align_done), 1);

    // Pattern never present: ten slips, then error with no eleventh pulse.
    applyStimulus(1'b0, 10'h000, 1'b1);
    runLink(0, 1'b1, 10'h000, 1'b0, 200);
    checkOutput("never_no_timeout", 32'(timedOut), 0);
    checkOutput("never_pulses", 32'(pulses), 10);
    checkOutput("never_latency", 32'(cyc), 52);
    checkOutput("never_error", 32'(align_error), 1);
    checkOutput("never_busy_low", 32'(align_busy), 0);
    checkOutput("never_slip_count", 32'(slip_count), 10);
    extraPulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 10'h000, 1'b0);
      if (bitslip_adj) extraPulses++;
    end
    checkOutput("never_no_11th_pulse", 32'(extraPulses), 0);
    checkOutput("never_error_sticky", 32'(align_error), 1);
    applyStimulus(1'b0, 10'h000, 1'b1);
    checkOutput("start_clears_error", 32'(align_error), 0);

    // Reset asserted while a bitslip pulse is in flight.
    applyStimulus(1'b1, 10'h000, 1'b0);
    applyStimulus(1'b1, 10'h000, 1'b0);
    checkOutput("pre_reset_pulse", 32'(bitslip_adj), 1);
    rx_reset = 1'b1;
    #1;
    checkOutput("async_reset_bitslip", 32'(bitslip_adj), 0);
    checkOutput("async_reset_busy", 32'(align_busy), 0);
    checkOutput("async_reset_slip_count", 32'(slip_count), 0);
    @(negedge core_clk);
    rx_reset = 1'b0;
    applyStimulus(1'b1, 10'h000, 1'b0);
    checkOutput("post_reset_idle", 32'(align_busy), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
